// File: rtl/serial_rx_pkg.sv
// Shared types and defaults for the framed serial receiver: FSM state encoding
// and the default bit period / word width.
package serial_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS    = 8;

endpackage

// File: rtl/bit_timer.sv
// Bit-period down-counter for the serial receiver. o_expire is high for the one
// cycle in which the count sits at 1, so the owner acts exactly i_load_val
// cycles after the load.
module bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          i_load,
  input  logic [$clog2(CLKS_PER_BIT):0] i_load_val,
  output logic                          o_expire
);

  localparam int            TW  = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [TW-1:0] ONE = TW'(1);

  logic [TW-1:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expire = (r_count == ONE);

endmodule

// File: rtl/serial_shift_receiver.sv
// Framed LSB-first serial receiver with a one-word valid/ready holding register.
// Define SERIAL_RX_PARITY_EN to expect and check one even-parity bit per frame.
module serial_shift_receiver
  import serial_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int            TW       = $clog2(CLKS_PER_BIT) + 1;
  localparam int            CW       = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] FULL_BIT = TW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  // Valid/ready: a word transfers in any cycle where out_valid and out_ready are
  // both 1; out_data is held stable from the rise of out_valid until that cycle.

  logic                 r_sync1;
  logic                 r_sync2;
  rx_state_t            r_state;
  logic [CW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_stop_bit;
  logic                 r_done;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic                 w_line;
  logic                 w_expire;
  logic                 w_tmr_load;
  logic [TW-1:0]        w_tmr_val;
  logic [DATA_BITS-1:0] w_shift_next;
  logic                 w_par_bad;
  logic                 w_hs;

  // Both stages reset high so leaving reset never looks like a start bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= serial_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_line = r_sync2;
  assign w_hs   = r_valid & out_ready;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clock     (clock),
    .reset     (reset),
    .i_load    (w_tmr_load),
    .i_load_val(w_tmr_val),
    .o_expire  (w_expire)
  );

  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = FULL_BIT;
    case (r_state)
      IDLE: begin
        if (!w_line) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = HALF_BIT;
        end
      end
      START:  w_tmr_load = w_expire & ~w_line;
      DATA:   w_tmr_load = w_expire;
`ifdef SERIAL_RX_PARITY_EN
      PARITY: w_tmr_load = w_expire;
`endif
      default: w_tmr_load = 1'b0;
    endcase
  end

  // Right shift: the newest sample lands in the MSB, so bit 0 ends up first-sent.
  always_comb begin
    w_shift_next                = r_shift >> 1;
    w_shift_next[DATA_BITS-1]   = w_line;
  end

`ifdef SERIAL_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;
  assign w_par_bad  = ^{r_shift, r_par_bit};
  assign parity_err = r_parity_err;
`else
  assign w_par_bad  = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_stop_bit  <= 1'b1;
      r_done      <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (!w_line) r_state <= START;
        end
        START: begin
          if (w_expire) begin
            r_bit_cnt <= '0;
            r_state   <= w_line ? IDLE : DATA;
          end
        end
        DATA: begin
          if (w_expire) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          if (w_expire) begin
            r_par_bit <= w_line;
            r_state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (w_expire) begin
            r_stop_bit <= w_line;
            r_done     <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Frame verdict is resolved one cycle after the stop sample; a load in
      // that cycle overrides the clear from a simultaneous handshake.
      if (w_hs) r_valid <= 1'b0;
      if (r_done) begin
        if (!r_stop_bit) begin
          r_frame_err <= 1'b1;
        end else if (w_par_bad) begin
`ifdef SERIAL_RX_PARITY_EN
          r_parity_err <= 1'b1;
`endif
        end else if (r_valid && !out_ready) begin
          r_overrun <= 1'b1;
        end else begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_serial_shift_receiver.sv
// Self-checking bench for serial_shift_receiver (CLKS_PER_BIT=4, DATA_BITS=8):
// a frame-level reference model checked every cycle, a vector table and corner sequences.
module tb_serial_shift_receiver;

  localparam int CPB = 4;
  localparam int DB  = 8;
`ifdef SERIAL_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  // Edges from the first clock that sees the start bit to out_valid / error pulse.
  localparam int LAT = 2 + CPB / 2 + (DB + 1 + P) * CPB + 1;

  logic          clock;
  logic          reset;
  logic          serial_in;
  logic          out_ready;
  logic [DB-1:0] out_data;
  logic          out_valid;
  logic          frame_err;
  logic          overrun;
  logic          parity_err;

  serial_shift_receiver #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .serial_in (serial_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int            due;
    logic [DB-1:0] data;
    logic          stop_ok;
    logic          par_ok;
  } ev_t;

  ev_t sent[128];
  int  n_sent = 0;
  int  n_done = 0;

  logic          m_valid = 1'b0;
  logic [DB-1:0] m_data  = '0;
  logic          m_ferr  = 1'b0;
  logic          m_ovr   = 1'b0;
  logic          m_perr  = 1'b0;

  // Reference model: each sent frame resolves LAT edges after its start edge.
  always @(posedge clock) begin : model
    logic hs;
    logic was_valid;
    ev_t  e;
    cyc       = cyc + 1;
    hs        = m_valid & out_ready;
    was_valid = m_valid;
    m_ferr    = 1'b0;
    m_ovr     = 1'b0;
    m_perr    = 1'b0;
    if (!reset) begin
      m_valid = 1'b0;
      m_data  = '0;
      n_done  = n_sent;
    end else begin
      if (hs) m_valid = 1'b0;
      if (n_done < n_sent && sent[n_done].due == cyc) begin
        e      = sent[n_done];
        n_done = n_done + 1;
        if (!e.stop_ok)              m_ferr = 1'b1;
        else if (!e.par_ok)          m_perr = 1'b1;
        else if (was_valid && !hs)   m_ovr  = 1'b1;
        else begin
          m_data  = e.data;
          m_valid = 1'b1;
        end
      end
    end
  end

  logic          rand_ready = 1'b0;
  logic          prev_valid = 1'b0;
  int            rise_edge  = 0;
  logic [DB-1:0] last_data  = '0;
  int            valid_cyc  = 0;
  int            ferr_cnt   = 0;
  int            ovr_cnt    = 0;
  int            perr_cnt   = 0;
  int            last_t0    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      @(negedge clock);
      check("outputs{valid,data,ferr,ovr,perr}",
            {out_valid, out_data, frame_err, overrun, parity_err},
            {m_valid, m_data, m_ferr, m_ovr, m_perr});
      if (out_valid && !prev_valid) begin
        rise_edge = cyc;
        last_data = out_data;
      end
      prev_valid = out_valid;
      valid_cyc += int'(out_valid);
      ferr_cnt  += int'(frame_err);
      ovr_cnt   += int'(overrun);
      perr_cnt  += int'(parity_err);
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    serial_in = b;
    hold(n);
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_b, input logic par_good);
    ev_t e;
    last_t0   = cyc + 1;
    e.due     = last_t0 + LAT;
    e.data    = d;
    e.stop_ok = stop_b;
    e.par_ok  = (P == 0) ? 1'b1 : par_good;
    sent[n_sent] = e;
    n_sent++;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < DB; i++) drive_bit(d[i], CPB);
`ifdef SERIAL_RX_PARITY_EN
    drive_bit(par_good ? ^d : ~^d, CPB);
`endif
    drive_bit(stop_b, CPB);
  endtask

  typedef struct {
    logic [DB-1:0] data;
    logic          stop_b;
    int            exp_valid_cyc;
    logic [DB-1:0] exp_data;
    int            exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int b_valid, b_ferr, b_ovr, b_perr;
    logic [DB-1:0] d;
    logic sb, pg;
    int gap;

    vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
    vecs[1] = '{8'h55, 1'b0, 0, 8'hA5, 1};
    vecs[2] = '{8'h3C, 1'b1, 1, 8'h3C, 0};
    vecs[3] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
    vecs[4] = '{8'h00, 1'b1, 1, 8'h00, 0};
    vecs[5] = '{8'h80, 1'b1, 1, 8'h80, 0};

    reset     = 1'b0;
    serial_in = 1'b1;
    out_ready = 1'b0;
    hold(4);
    check("reset_state", {out_valid, out_data, frame_err, overrun, parity_err}, 32'h0);

    reset = 1'b1;
    idle(50);
    check("idle_no_valid", valid_cyc, 0);
    check("idle_no_errors", ferr_cnt + ovr_cnt + perr_cnt, 0);

    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b_valid = valid_cyc;
      b_ferr  = ferr_cnt;
      send_frame(vecs[i].data, vecs[i].stop_b, 1'b1);
      idle(4);
      check("vec_valid_cycles", valid_cyc - b_valid, vecs[i].exp_valid_cyc);
      check("vec_frame_err", ferr_cnt - b_ferr, vecs[i].exp_ferr);
      check("vec_out_data", out_data, vecs[i].exp_data);
      if (vecs[i].exp_valid_cyc != 0) begin
        check("vec_latency", rise_edge - last_t0, LAT);
        check("vec_captured", last_data, vecs[i].exp_data);
      end
    end

    // Two frames back-to-back into a full holding register.
    out_ready = 1'b0;
    b_ovr     = ovr_cnt;
    send_frame(8'h3C, 1'b1, 1'b1);
    send_frame(8'hC3, 1'b1, 1'b1);
    idle(4);
    check("overrun_pulses", ovr_cnt - b_ovr, 1);
    check("overrun_held_data", out_data, 8'h3C);
    check("overrun_still_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    idle(2);
    check("drain_clears_valid", out_valid, 1'b0);

    // Short low glitch on an idle line.
    b_valid = valid_cyc;
    b_ferr  = ferr_cnt;
    drive_bit(1'b0, 2);
    idle(20);
    check("glitch_no_valid", valid_cyc - b_valid, 0);
    check("glitch_no_ferr", ferr_cnt - b_ferr, 0);
    send_frame(8'h01, 1'b1, 1'b1);
    idle(4);
    check("after_glitch_data", last_data, 8'h01);
    check("after_glitch_valid", valid_cyc - b_valid, 1);

    // Reset in the middle of the data bits.
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b0, CPB);
    reset     = 1'b0;
    serial_in = 1'b1;
    hold(3);
    check("reset_mid_data_out", out_data, 8'h00);
    reset = 1'b1;
    idle(8);
    send_frame(8'h7E, 1'b1, 1'b1);
    idle(4);
    check("after_reset_data", last_data, 8'h7E);

`ifdef SERIAL_RX_PARITY_EN
    b_valid = valid_cyc;
    send_frame(8'h07, 1'b1, 1'b1);
    idle(4);
    check("parity_good_data", last_data, 8'h07);
    check("parity_good_valid", valid_cyc - b_valid, 1);
    b_valid = valid_cyc;
    b_perr  = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(4);
    check("parity_bad_pulse", perr_cnt - b_perr, 1);
    check("parity_bad_no_valid", valid_cyc - b_valid, 0);
`else
    b_perr = perr_cnt;
    idle(2);
    check("parity_err_tied_low", perr_cnt - b_perr, 0);
`endif

    // Random frames, gaps and consumer backpressure against the model.
    rand_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      d   = DB'($urandom);
      sb  = ($urandom_range(0, 7) != 0);
      pg  = ($urandom_range(0, 7) != 0);
      send_frame(d, sb, pg);
      gap = sb ? $urandom_range(0, 6) : CPB + $urandom_range(0, 4);
      if (gap > 0) idle(gap);
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    idle(60);
    check("all_frames_resolved", n_done, n_sent);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_shift_receiver.md
# serial_shift_receiver

Framed serial-to-parallel receiver: the receiving end of the team's right-rotating serial shift path. It samples a single-wire, idle-high, LSB-first bitstream and reassembles each frame into a parallel word by shifting right, the same direction the transmit-side shift register uses. The completed word is presented on a valid/ready output port backed by a one-word holding register. It sits between an external serial pin and the parallel datapath.

## Interface
- CLKS_PER_BIT, 16, clock cycles per serial bit; even, ≥4
- DATA_BITS, 8, data bits per frame; 1–16
- clock  input  1  rising-edge clock for all state
- reset  input  1  asynchronous, active-low; 0 forces the reset state immediately
- serial_in  input  1  asynchronous serial line, idle high
- out_data  output  DATA_BITS  received word, LSB = first data bit
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  consumer accepts out_data in a cycle where out_valid=1
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: word completed while holding register full
- parity_err  output  1  one-cycle pulse: parity mismatch; constant 0 when parity is not compiled in

## Operation
- serial_in passes through a 2-FF synchronizer. Both flops reset to 1 so reset never creates a false start.
- States:
  - IDLE: wait for the synchronized line to read 0, then load the bit timer with CLKS_PER_BIT/2 and enter START.
  - START: when the timer expires, sample the line.
    - 0: go to DATA with bit count 0 and the timer reloaded with CLKS_PER_BIT.
    - 1: glitch; return to IDLE with no error.
  - DATA: on each expiry, shift right (sample enters the MSB) and increment the count. After DATA_BITS samples, go to PARITY if compiled in, else STOP.
  - PARITY: sample the parity bit, then go to STOP.
  - STOP: sample the line and return to IDLE.
- Stop-bit sample outcomes, in priority order:
  - stop = 0: frame_err pulses and the word is discarded.
  - Parity mismatch: parity_err pulses and the word is discarded.
  - Holding register full and not consumed this cycle: overrun pulses, the new word is dropped, and the old word is retained.
  - Otherwise: load out_data and set out_valid.
- out_valid clears on the cycle after a cycle where out_valid & out_ready.
- If the stop sample and a handshake (out_valid & out_ready) occur in the same cycle, the new word loads with no overrun, and out_valid stays 1.
- out_data is stable while out_valid=1 and has not been handshaken.
- Reset at any point, including mid-frame:
  - state returns to IDLE and the timer and count clear
  - out_data=0, out_valid=0, all error pulses 0
  - any partial word is lost

## Timing
- Reset values: out_data=0, out_valid=0, frame_err=0, overrun=0, parity_err=0.
- Latency from the first clock where serial_in=0 at the start edge to out_valid=1:
  - 2 + CLKS_PER_BIT/2 + (DATA_BITS+1+P)×CLKS_PER_BIT + 1 cycles
  - P=1 with parity compiled in, else 0
  - defaults: 2+8+144+1 = 155 cycles
- Error pulses assert in the same cycle that out_valid would otherwise rise, for exactly one cycle.
- Back-to-back frames (stop immediately followed by start) are received with no lost word. IDLE is re-entered in the cycle after the stop sample.
- out_ready has no combinational path to any output.

## Configuration
- Macro SERIAL_RX_PARITY_EN.
  - Defined: one even-parity bit follows the data bits; parity is the XOR of the data bits and the parity bit, and must be 0; the PARITY state exists.
  - Undefined: no parity bit is expected; the PARITY state and checker are not built; parity_err is tied to 0.

## Structure
- Package serial_rx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP)
  - default constants for CLKS_PER_BIT and DATA_BITS
- One sub-module, bit_timer:
  - down-counter of width $clog2(CLKS_PER_BIT)+1
  - inputs: load value and load strobe
  - output: expire pulse

## Test plan
Benches run with CLKS_PER_BIT=4 and DATA_BITS=8 unless stated.
- Reset released, line idle high for 50 cycles -> out_valid stays 0 and no error pulses.
- Frame 0xA5 sent LSB-first, stop=1, out_ready=1 -> out_data=0xA5 and out_valid rises 41 cycles after the start edge, for 1 cycle.
- 0x3C then 0xC3 back-to-back with out_ready=0 -> 0x3C is held, an overrun pulse occurs at the second stop sample, and out_data stays 0x3C.
- 2-cycle low glitch on an idle line -> no output and no errors; the next valid frame 0x01 is received correctly.
- Frame 0x55 with stop bit 0 -> frame_err pulses once and out_valid stays 0. reset pulled low mid-DATA, then 0x7E sent -> out_data=0x7E.
- With SERIAL_RX_PARITY_EN:
  - 0x07 with parity bit 1 -> received correctly
  - 0x07 with parity bit 0 -> parity_err pulses and out_valid stays 0
